// File: rtl/fixed_to_float_sched.sv
`default_nettype none
// ============================================================================
// Module      : fixed_to_float_sched (with helper fixed_to_float_sp)
// Description : Round-robin scheduler sharing one two-stage signed-32-bit
//               to IEEE-754 single converter among p_NUM_REQ requesters.
//               Each issued word is tagged with its requester ID, the zero
//               flag is aligned with the converter result, and tagged
//               results are returned in issue order through a
//               credit-protected response FIFO.
// Ports       : i_CLK, i_RST          clock, synchronous active-high reset
//               i_REQ_VALID/DATA      per-requester request channel
//               o_REQ_READY           one-hot (or zero) accept
//               o_RSP_VALID/ID/DATA/ZERO, i_RSP_READY   response channel
// Options     : F2F_SCHED_STRICT_PRIORITY_EN - fixed priority (requester 0
//               highest) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// fixed_to_float_sp: non-stallable converter, 2-cycle latency.
//   Stage 1 registers sign, magnitude and zero flag (o_INVALID).
//   Stage 2 normalises and registers the float (mantissa truncated).
// ----------------------------------------------------------------------------
module fixed_to_float_sp (
  input  logic        i_CLK,
  input  logic [31:0] i_DATA,
  output logic [31:0] o_RESULT,
  output logic        o_INVALID
);
  logic        r_s1_sign;
  logic [31:0] r_s1_mag;
  logic        r_s1_zero;
  logic [31:0] r_result;
  logic [31:0] w_abs;
  logic [4:0]  w_msb;
  logic [7:0]  w_exp;
  logic [22:0] w_mant;

  // Two's complement magnitude; 32'h8000_0000 maps onto itself, which is the
  // correct unsigned magnitude 2^31.
  assign w_abs = i_DATA[31] ? (~i_DATA + 32'd1) : i_DATA;

  always_ff @(posedge i_CLK) begin
    r_s1_sign <= i_DATA[31];
    r_s1_mag  <= w_abs;
    r_s1_zero <= (i_DATA == 32'd0);
  end

  always_comb begin
    w_msb = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (r_s1_mag[i]) w_msb = 5'(i);
    end
  end

  // Left-justify the magnitude, drop the implicit leading one and keep the
  // next 23 bits; lower bits are discarded (truncation).
  assign w_mant = 23'((r_s1_mag << (5'd31 - w_msb)) >> 8);
  assign w_exp  = 8'd127 + {3'd0, w_msb};

  always_ff @(posedge i_CLK) begin
    r_result <= r_s1_zero ? 32'd0 : {r_s1_sign, w_exp, w_mant};
  end

  assign o_RESULT  = r_result;
  assign o_INVALID = r_s1_zero;
endmodule

// ----------------------------------------------------------------------------
// fixed_to_float_sched: top level
// ----------------------------------------------------------------------------
module fixed_to_float_sched #(
  parameter int p_NUM_REQ    = 4,
  parameter int p_DATA_WIDTH = 32,
  parameter int p_FIFO_DEPTH = 4
) (
  input  logic                              i_CLK,
  input  logic                              i_RST,
  input  logic [p_NUM_REQ-1:0]              i_REQ_VALID,
  input  logic [p_NUM_REQ*p_DATA_WIDTH-1:0] i_REQ_DATA,
  output logic [p_NUM_REQ-1:0]              o_REQ_READY,
  output logic                              o_RSP_VALID,
  output logic [$clog2(p_NUM_REQ)-1:0]      o_RSP_ID,
  output logic [p_DATA_WIDTH-1:0]           o_RSP_DATA,
  output logic                              o_RSP_ZERO,
  input  logic                              i_RSP_READY
);
  localparam int c_ID_W  = $clog2(p_NUM_REQ);
  localparam int c_PTR_W = $clog2(p_FIFO_DEPTH);
  localparam int c_CRD_W = $clog2(p_FIFO_DEPTH + 1);
  localparam logic [c_CRD_W-1:0] c_CRD_MAX = c_CRD_W'(p_FIFO_DEPTH);

  logic                    w_grant_found;
  logic [c_ID_W-1:0]       w_grant_idx;
  logic                    w_issue;
  logic                    w_pop;
  logic [p_DATA_WIDTH-1:0] w_issue_data;
  logic [p_DATA_WIDTH-1:0] w_conv_result;
  logic                    w_conv_zero;
  logic                    w_empty;

  logic [c_CRD_W-1:0]      r_credits;
  logic                    r_tag_v1;
  logic                    r_tag_v2;
  logic [c_ID_W-1:0]       r_tag_id1;
  logic [c_ID_W-1:0]       r_tag_id2;
  logic                    r_zero_d;
  logic [c_PTR_W:0]        r_wr_ptr;
  logic [c_PTR_W:0]        r_rd_ptr;
  logic [p_DATA_WIDTH-1:0] r_mem_data [p_FIFO_DEPTH];
  logic [c_ID_W-1:0]       r_mem_id   [p_FIFO_DEPTH];
  logic                    r_mem_zero [p_FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef F2F_SCHED_STRICT_PRIORITY_EN
  // Lowest-index valid requester wins; scanning downward leaves it last.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int i = p_NUM_REQ - 1; i >= 0; i--) begin
      if (i_REQ_VALID[i]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = c_ID_W'(i);
      end
    end
  end
`else
  localparam logic [c_ID_W-1:0] c_LAST_ID = c_ID_W'(p_NUM_REQ - 1);
  logic [c_ID_W-1:0] r_rr_ptr;

  // First valid requester at or after r_rr_ptr, wrapping around.
  always_comb begin : p_rr_grant
    int v_j;
    v_j           = 0;
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int i = 0; i < p_NUM_REQ; i++) begin
      v_j = int'(r_rr_ptr) + i;
      if (v_j >= p_NUM_REQ) v_j = v_j - p_NUM_REQ;
      if (!w_grant_found && i_REQ_VALID[v_j]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = c_ID_W'(v_j);
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_rr_ptr <= '0;
    end else if (w_issue) begin
      r_rr_ptr <= (w_grant_idx == c_LAST_ID) ? '0 : w_grant_idx + 1'b1;
    end
  end
`endif

  // Only the registered credit count gates issue, so a pop while full does
  // not open a slot until the following cycle.
  assign w_issue = w_grant_found && (r_credits < c_CRD_MAX);
  assign w_pop   = o_RSP_VALID && i_RSP_READY;

  always_comb begin
    o_REQ_READY = '0;
    if (w_issue) o_REQ_READY[w_grant_idx] = 1'b1;
  end

  assign w_issue_data = i_REQ_DATA[w_grant_idx*p_DATA_WIDTH +: p_DATA_WIDTH];

  // --------------------------------------------------------------------------
  // Credits: one per word issued and not yet popped from the FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_credits <= '0;
    end else begin
      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits + 1'b1;
        2'b01:   r_credits <= r_credits - 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Shared converter and tag pipeline matching its 2-cycle latency
  // --------------------------------------------------------------------------
  fixed_to_float_sp u_conv (
    .i_CLK     (i_CLK),
    .i_DATA    (w_issue_data),
    .o_RESULT  (w_conv_result),
    .o_INVALID (w_conv_zero)
  );

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_tag_v1  <= 1'b0;
      r_tag_v2  <= 1'b0;
      r_tag_id1 <= '0;
      r_tag_id2 <= '0;
      r_zero_d  <= 1'b0;
    end else begin
      r_tag_v1  <= w_issue;
      r_tag_v2  <= r_tag_v1;
      r_tag_id1 <= w_grant_idx;
      r_tag_id2 <= r_tag_id1;
      // Zero flag leaves the converter one stage early; delay it once.
      r_zero_d  <= w_conv_zero;
    end
  end

  // --------------------------------------------------------------------------
  // Response FIFO (extra pointer bit distinguishes full from empty)
  // --------------------------------------------------------------------------
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (r_tag_v2) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (r_tag_v2) begin
      r_mem_data[r_wr_ptr[c_PTR_W-1:0]] <= r_zero_d ? '0 : w_conv_result;
      r_mem_id[r_wr_ptr[c_PTR_W-1:0]]   <= r_tag_id2;
      r_mem_zero[r_wr_ptr[c_PTR_W-1:0]] <= r_zero_d;
    end
  end

  assign o_RSP_VALID = !w_empty;
  assign o_RSP_DATA  = o_RSP_VALID ? r_mem_data[r_rd_ptr[c_PTR_W-1:0]] : '0;
  assign o_RSP_ID    = o_RSP_VALID ? r_mem_id[r_rd_ptr[c_PTR_W-1:0]]   : '0;
  assign o_RSP_ZERO  = o_RSP_VALID ? r_mem_zero[r_rd_ptr[c_PTR_W-1:0]] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_fixed_to_float_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_fixed_to_float_sched
// Description : Self-checking bench for fixed_to_float_sched. A queue-based
//               reference model predicts grants, credit blocking and the
//               in-order tagged responses; float values are computed from
//               the integer magnitude with plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_to_float_sched;
  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*32-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [31:0]       rsp_data;
  logic              rsp_zero;
  logic              rsp_ready;

  always #5 clk = ~clk;

  fixed_to_float_sched #(
    .p_NUM_REQ    (N),
    .p_DATA_WIDTH (32),
    .p_FIFO_DEPTH (DEPTH)
  ) dut (
    .i_CLK       (clk),
    .i_RST       (rst),
    .i_REQ_VALID (req_valid),
    .i_REQ_DATA  (req_data),
    .o_REQ_READY (req_ready),
    .o_RSP_VALID (rsp_valid),
    .o_RSP_ID    (rsp_id),
    .o_RSP_DATA  (rsp_data),
    .o_RSP_ZERO  (rsp_zero),
    .i_RSP_READY (rsp_ready)
  );

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        zero;
    int          ready_at;
  } ent_t;

  ent_t         q[$];
  int           m_rr, m_credits, cyc;
  int           errors, checks;
  bit           auto_stim;
  int           valid_pct, rsp_pct;
  logic [N-1:0] last_acc;
  logic [31:0]  corners [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000};

  // Signed integer to single float, truncating the mantissa.
  function automatic logic [31:0] ref_float(input logic [31:0] x);
    longint m;
    longint mant;
    int     e;
    if (x == 32'd0) return 32'd0;
    m = longint'(signed'(x));
    if (m < 0) m = -m;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    mant = ((m << 23) >> e) & 64'h7F_FFFF;
    return {x[31], 8'(127 + e), mant[22:0]};
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int k;
    logic [N-1:0] r;
    r = '0;
    if (m_credits >= DEPTH) return r;
    for (int i = 0; i < N; i++) begin
`ifdef F2F_SCHED_STRICT_PRIORITY_EN
      k = i;
`else
      k = (m_rr + i) % N;
`endif
      if (req_valid[k]) begin
        r[k] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'($urandom_range(255));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic stim();
    for (int k = 0; k < N; k++) begin
      if (last_acc[k] || !req_valid[k]) begin
        req_valid[k]          = (int'($urandom_range(99)) < valid_pct);
        req_data[k*32 +: 32]  = rand_word();
      end
    end
    rsp_ready = (int'($urandom_range(99)) < rsp_pct);
  endtask

  // One clock: check at the falling edge, update the model at the rising
  // edge, then drive new inputs 1 time unit later.
  task automatic tick();
    logic [N-1:0] er;
    logic         pop;
    ent_t         e;
    er  = '0;
    pop = 1'b0;
    @(negedge clk);
    if (!rst) begin
      er = exp_ready();
      chk("req_ready", 64'(req_ready), 64'(er));
      if (q.size() > 0 && q[0].ready_at <= cyc) begin
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_fields", {29'd0, rsp_id, rsp_zero, rsp_data},
            {29'd0, 2'(q[0].id), q[0].zero, q[0].data});
        pop = rsp_ready;
      end else begin
        chk("rsp_idle", {29'd0, rsp_valid, rsp_id, rsp_zero, rsp_data}, 64'd0);
      end
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      m_credits = 0;
      m_rr      = 0;
      er        = '0;
    end else begin
      if (pop) begin
        e = q.pop_front();
        m_credits--;
      end
      for (int k = 0; k < N; k++) begin
        if (er[k]) begin
          e.id       = k;
          e.zero     = (req_data[k*32 +: 32] == 32'd0);
          e.data     = ref_float(req_data[k*32 +: 32]);
          e.ready_at = cyc + 2;
          q.push_back(e);
          m_credits++;
          m_rr = (k + 1) % N;
        end
      end
    end
    last_acc = er;
    #1;
    if (auto_stim) stim();
  endtask

  task automatic phase(input int vp, input int rp, input int n);
    auto_stim = 1'b1;
    valid_pct = vp;
    rsp_pct   = rp;
    stim();
    repeat (n) tick();
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; m_rr = 0; m_credits = 0;
    auto_stim = 1'b0; valid_pct = 0; rsp_pct = 100; last_acc = '0;
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Single request from requester 2
    req_valid[2] = 1'b1;
    req_data[95:64] = 32'h0000_0001;
    tick();
    req_valid[2] = 1'b0;
    repeat (4) tick();

    // Corner values from requester 0, back to back
    for (int i = 0; i < 4; i++) begin
      req_valid[0]    = 1'b1;
      req_data[31:0]  = corners[i];
      tick();
    end
    req_valid[0] = 1'b0;
    repeat (5) tick();

    // All requesters valid, consumer always ready
    phase(100, 100, 24);
    // Consumer stalled, then released
    phase(100, 0, 8);
    phase(100, 100, 10);

    // Drain, then build up 2 entries in the FIFO and 2 in flight
    phase(0, 100, 8);
    phase(100, 0, 4);
    auto_stim = 1'b0;
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    phase(100, 100, 12);

    // Random traffic and backpressure, then drain
    phase(60, 70, 400);
    phase(0, 100, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
